// File: rtl/dram_rd_rsp_assembler.sv
// dram_rd_rsp_assembler: turns the serial DRAM read stream into address-tagged
// DATA_WIDTH-bit words and queues them in a first-word-fall-through response
// FIFO towards L2.
// Optional build macro: RD_TIMEOUT_EN closes a word early after
// TIMEOUT_CYCLES consecutive idle cycles and flags it with l2_rsp_err.
module dram_rd_rsp_assembler #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 20,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          rd_start,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_ready,
  input  logic                          dram_bit_valid,
  input  logic                          dram_bit,
  input  logic                          flush,
  output logic                          l2_rsp_valid,
  input  logic                          l2_rsp_ready,
  output logic [DATA_WIDTH-1:0]         l2_rsp_data,
  output logic [ADDR_WIDTH-1:0]         l2_rsp_addr,
  output logic                          l2_rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]   rsp_count
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [ADDR_WIDTH-1:0]   addr_q;

`ifdef RD_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0]        gap_cnt;
  logic                    err_q;
`endif

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [OCC_W-1:0]        count;
  logic                    empty;
  logic                    full;
  logic                    pop;
  logic                    push;

  logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   hold_data;
  logic [ADDR_WIDTH-1:0]   hold_addr;

  assign empty        = (count == '0);
  assign full         = (count == OCC_W'(FIFO_DEPTH));
  assign pop          = !flush && !empty && l2_rsp_ready;
  // A full FIFO still accepts the word when the head leaves in the same cycle.
  assign push         = !flush && (state == PUSH) && (!full || pop);
  assign rd_ready     = (state == IDLE);
  assign l2_rsp_valid = !empty;
  assign rsp_count    = count;
  assign l2_rsp_data  = empty ? hold_data : mem_data[rd_ptr];
  assign l2_rsp_addr  = empty ? hold_addr : mem_addr[rd_ptr];

  // Word assembly FSM: accept a read, collect serial beats, hand the word to the FIFO.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      addr_q  <= '0;
`ifdef RD_TIMEOUT_EN
      gap_cnt <= '0;
      err_q   <= 1'b0;
`endif
    end else if (flush) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
`ifdef RD_TIMEOUT_EN
      gap_cnt <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_start) begin
            addr_q  <= rd_addr;
            shift_q <= '0;
            bit_cnt <= '0;
`ifdef RD_TIMEOUT_EN
            gap_cnt <= '0;
            err_q   <= 1'b0;
`endif
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (dram_bit_valid) begin
            // NOTE: state registers use non-blocking assignments so every
            // branch here sees the pre-edge bit_cnt, matching the hardware.
            shift_q[bit_cnt] <= dram_bit;
`ifdef RD_TIMEOUT_EN
            gap_cnt <= '0;
`endif
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state <= PUSH;
            else bit_cnt <= bit_cnt + 1'b1;
          end
`ifdef RD_TIMEOUT_EN
          else if (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1)) begin
            // Silence limit reached: close the partial word, missing bits stay 0.
            err_q <= 1'b1;
            state <= PUSH;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
`endif
        end
        PUSH: begin
          if (push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; the outputs read the
  // hold registers whenever the FIFO is empty, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= shift_q;
      mem_addr[wr_ptr] <= addr_q;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Remember what was last presented so the data bus holds steady once empty.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hold_data <= '0;
      hold_addr <= '0;
    end else begin
      hold_data <= l2_rsp_data;
      hold_addr <= l2_rsp_addr;
    end
  end

`ifdef RD_TIMEOUT_EN
  logic mem_err [FIFO_DEPTH];
  logic hold_err;

  assign l2_rsp_err = empty ? hold_err : mem_err[rd_ptr];

  // Error flag storage travels alongside each queued word.
  always_ff @(posedge clk) begin
    if (push) mem_err[wr_ptr] <= err_q;
  end

  // Hold the last presented error flag while empty.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) hold_err <= 1'b0;
    else        hold_err <= l2_rsp_err;
  end
`else
  assign l2_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_rd_rsp_assembler.sv
// Self-checking bench for dram_rd_rsp_assembler: vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_dram_rd_rsp_assembler;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int FD = 4;
  localparam int TO = 64;
  localparam int NV = 6;
  localparam int NW = 40;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready;
  logic          dram_bit_valid = 1'b0;
  logic          dram_bit = 1'b0;
  logic          flush = 1'b0;
  logic          l2_rsp_valid;
  logic          l2_rsp_ready = 1'b0;
  logic [DW-1:0] l2_rsp_data;
  logic [AW-1:0] l2_rsp_addr;
  logic          l2_rsp_err;
  logic [$clog2(FD):0] rsp_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic busy_ok;

  // beats lists the serial bits in time order: beats[DW-1] is sent first.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] beats;
    int            gap;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } word_t;

  vec_t  vecs [NV];
  word_t exp_q [$];

  always #5 clk = ~clk;

  dram_rd_rsp_assembler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_b(rst_b), .rd_start(rd_start), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .dram_bit_valid(dram_bit_valid), .dram_bit(dram_bit),
    .flush(flush), .l2_rsp_valid(l2_rsp_valid), .l2_rsp_ready(l2_rsp_ready),
    .l2_rsp_data(l2_rsp_data), .l2_rsp_addr(l2_rsp_addr), .l2_rsp_err(l2_rsp_err),
    .rsp_count(rsp_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (rd_ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (rd_ready !== 1'b1) check("rd_ready_wait_expired", rd_ready, 1);
  endtask

  // Issue a read and stream its beats; returns right after the last beat edge.
  task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] beats,
                           input int gap, output logic ok);
    wait_ready(500);
    rd_start = 1'b1;
    rd_addr  = a;
    step();
    rd_start = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < DW; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          dram_bit_valid = 1'b0;
          dram_bit       = ~beats[DW-1-i];
          step();
          if (rd_ready !== 1'b0) ok = 1'b0;
        end
      end
      dram_bit_valid = 1'b1;
      dram_bit       = beats[DW-1-i];
      step();
      if (rd_ready !== 1'b0) ok = 1'b0;
    end
    dram_bit_valid = 1'b0;
    dram_bit       = 1'b0;
  endtask

  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] beats);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = beats[DW-1-i];
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{addr: 20'h01234, beats: 8'b1010_0101, gap: 0, exp_data: 8'hA5, exp_addr: 20'h01234};
    vecs[1] = '{addr: 20'hABCDE, beats: 8'b0011_1100, gap: 3, exp_data: 8'h3C, exp_addr: 20'hABCDE};
    vecs[2] = '{addr: 20'hFFFFF, beats: 8'b1000_0000, gap: 1, exp_data: 8'h01, exp_addr: 20'hFFFFF};
    vecs[3] = '{addr: 20'h00000, beats: 8'b0000_0001, gap: 0, exp_data: 8'h80, exp_addr: 20'h00000};
    vecs[4] = '{addr: 20'h80001, beats: 8'b1100_1010, gap: 2, exp_data: 8'h53, exp_addr: 20'h80001};
    vecs[5] = '{addr: 20'h5A5A5, beats: 8'b1111_1111, gap: 0, exp_data: 8'hFF, exp_addr: 20'h5A5A5};

    // Reset state.
    #12;
    check("rst_valid", l2_rsp_valid, 0);
    check("rst_data", l2_rsp_data, 0);
    check("rst_addr", l2_rsp_addr, 0);
    check("rst_err", l2_rsp_err, 0);
    check("rst_count", rsp_count, 0);
    rst_b = 1'b1;
    step();
    check("rst_rd_ready", rd_ready, 1);

    // Table vectors: latency, content, pop, hold-after-empty, stray beats in IDLE.
    for (int v = 0; v < NV; v++) begin
      send_word(vecs[v].addr, vecs[v].beats, vecs[v].gap, busy_ok);
      check($sformatf("v%0d_busy_during_word", v), busy_ok, 1);
      check($sformatf("v%0d_valid_at_last_beat", v), l2_rsp_valid, 0);
      step();
      check($sformatf("v%0d_valid", v), l2_rsp_valid, 1);
      check($sformatf("v%0d_rd_ready", v), rd_ready, 1);
      check($sformatf("v%0d_data", v), l2_rsp_data, vecs[v].exp_data);
      check($sformatf("v%0d_addr", v), l2_rsp_addr, vecs[v].exp_addr);
      check($sformatf("v%0d_err", v), l2_rsp_err, 0);
      check($sformatf("v%0d_count", v), rsp_count, 1);
      l2_rsp_ready = 1'b1;
      step();
      l2_rsp_ready = 1'b0;
      check($sformatf("v%0d_valid_after_pop", v), l2_rsp_valid, 0);
      check($sformatf("v%0d_data_held", v), l2_rsp_data, vecs[v].exp_data);
      check($sformatf("v%0d_count_after_pop", v), rsp_count, 0);
      dram_bit_valid = 1'b1;
      dram_bit       = 1'b1;
      step();
      dram_bit_valid = 1'b0;
      dram_bit       = 1'b0;
      check($sformatf("v%0d_idle_beat_ignored", v), rd_ready, 1);
    end

    // Backpressure: five words into a four-deep FIFO.
    for (int k = 1; k <= 5; k++) begin
      logic [DW-1:0] d;
      d = DW'(k);
      send_word(AW'(20'h00010 + k), model_word(d), 0, busy_ok);
    end
    step();
    step();
    check("bp_count_full", rsp_count, 4);
    check("bp_rd_ready_stuck", rd_ready, 0);
    check("bp_head", l2_rsp_data, 8'h01);
    l2_rsp_ready = 1'b1;
    step();
    l2_rsp_ready = 1'b0;
    check("bp_count_push_pop", rsp_count, 4);
    check("bp_rd_ready_released", rd_ready, 1);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("bp_drain_data_%0d", k), l2_rsp_data, k);
      check($sformatf("bp_drain_addr_%0d", k), l2_rsp_addr, 20'h00010 + k);
      l2_rsp_ready = 1'b1;
      step();
      l2_rsp_ready = 1'b0;
    end
    check("bp_empty", rsp_count, 0);

    // Flush with two words queued and three bits shifted, with a pop pending.
    send_word(20'h00111, 8'hAA, 0, busy_ok);
    send_word(20'h00222, 8'h55, 0, busy_ok);
    wait_ready(50);
    rd_start = 1'b1; rd_addr = 20'h00333; step(); rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dram_bit_valid = 1'b1; dram_bit = 1'b1; step();
    end
    dram_bit_valid = 1'b0;
    check("fl_pre_count", rsp_count, 2);
    flush = 1'b1; l2_rsp_ready = 1'b1;
    step();
    flush = 1'b0; l2_rsp_ready = 1'b0;
    check("fl_count", rsp_count, 0);
    check("fl_valid", l2_rsp_valid, 0);
    check("fl_rd_ready", rd_ready, 1);
    flush = 1'b1; rd_start = 1'b1; rd_addr = 20'h00444;
    step();
    flush = 1'b0; rd_start = 1'b0;
    check("fl_rd_start_ignored", rd_ready, 1);

    // Asynchronous reset with two words queued and three bits shifted.
    send_word(20'h00555, 8'hAA, 0, busy_ok);
    send_word(20'h00666, 8'h55, 0, busy_ok);
    wait_ready(50);
    rd_start = 1'b1; rd_addr = 20'h00777; step(); rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dram_bit_valid = 1'b1; dram_bit = 1'b1; step();
    end
    dram_bit_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("ar_count", rsp_count, 0);
    check("ar_valid", l2_rsp_valid, 0);
    check("ar_rd_ready", rd_ready, 1);
    check("ar_data", l2_rsp_data, 0);
    #2;
    rst_b = 1'b1;
    step();
    send_word(20'h00888, 8'b1000_0000, 0, busy_ok);
    step();
    check("ar_next_word_data", l2_rsp_data, 8'h01);
    check("ar_next_word_addr", l2_rsp_addr, 20'h00888);
    l2_rsp_ready = 1'b1; step(); l2_rsp_ready = 1'b0;

    // Beat-gap timeout behaviour.
    wait_ready(50);
    rd_start = 1'b1; rd_addr = 20'h00999; step(); rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dram_bit_valid = 1'b1; dram_bit = 1'b1; step();
    end
    dram_bit_valid = 1'b0;
`ifdef RD_TIMEOUT_EN
    for (int i = 0; i < TO; i++) step();
    check("to_not_yet_valid", l2_rsp_valid, 0);
    step();
    check("to_valid", l2_rsp_valid, 1);
    check("to_data", l2_rsp_data, 8'h07);
    check("to_addr", l2_rsp_addr, 20'h00999);
    check("to_err", l2_rsp_err, 1);
    check("to_rd_ready", rd_ready, 1);
    l2_rsp_ready = 1'b1; step(); l2_rsp_ready = 1'b0;
`else
    for (int i = 0; i < 200; i++) step();
    check("nto_valid", l2_rsp_valid, 0);
    check("nto_rd_ready", rd_ready, 0);
    check("nto_count", rsp_count, 0);
    flush = 1'b1; step(); flush = 1'b0;
    check("nto_flush_recover", rd_ready, 1);
`endif

    // Randomized traffic against an in-order queue model.
    fork
      begin : producer
        for (int w = 0; w < NW; w++) begin
          logic [DW-1:0] b;
          logic [AW-1:0] a;
          word_t         e;
          b = DW'($urandom);
          a = AW'($urandom);
          e.addr = a;
          e.data = model_word(b);
          exp_q.push_back(e);
          send_word(a, b, $urandom_range(0, 2), busy_ok);
        end
      end
      begin : consumer
        int    got = 0;
        int    cyc = 0;
        word_t e;
        while (got < NW && cyc < 5000) begin
          l2_rsp_ready = 1'($urandom_range(0, 1));
          if (l2_rsp_valid && l2_rsp_ready) begin
            if (exp_q.size() == 0) begin
              check("rnd_spurious_word", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("rnd_data_%0d", got), l2_rsp_data, e.data);
              check($sformatf("rnd_addr_%0d", got), l2_rsp_addr, e.addr);
            end
            got++;
          end
          step();
          cyc++;
        end
        l2_rsp_ready = 1'b0;
        check("rnd_word_total", got, NW);
      end
    join
    step();
    check("rnd_final_count", rsp_count, 0);
    check("rnd_final_valid", l2_rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
